// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment scan path.
package display_pkg;

  typedef enum logic [1:0] {OFF, GUARD, ON} scan_state_t;

  localparam int NUM_DIGITS = 8;
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 8'hFF;

  // True when nibbles k..7 of value are all zero (digit k is a leading zero).
  function automatic logic nibble_zero_above(input logic [31:0] value, input logic [2:0] k);
    return (value >> {k, 2'b00}) == 32'd0;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Per-digit slot timer: counts REFRESH_DIV-1 down to 0, then reloads.
// The first GUARD counts of each slot are the dead-time window.
module refresh_prescaler #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic guard_end,
  output logic slot_end
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins; a zero count reloads so a cleared timer starts a fresh slot.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (run)
      cnt_d = (cnt_q == '0) ? CW'(REFRESH_DIV - 1) : cnt_q - CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign guard_end = (cnt_q == CW'(REFRESH_DIV - GUARD));
  assign slot_end  = (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit scan controller: digit sequencing with dead time, leading-zero
// blanking, and a pending-value handshake that commits only at frame wrap.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int number_input_width = 32,
  parameter int width              = 3,
  parameter int REFRESH_DIV        = 100000,
  parameter int GUARD              = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          blank_lz,
  input  logic                          valid_in,
  input  logic [number_input_width-1:0] numero_in,
  output logic                          ready_out,
  output logic [number_input_width-1:0] numero,
  output logic [width-1:0]              counter,
  output logic [NUM_DIGITS-1:0]         anodes,
  output logic                          frame_done
);

  display_pkg::scan_state_t state_q;
  logic [width-1:0]              counter_q;
  logic [number_input_width-1:0] numero_q, pend_q;
  logic                          pend_full_q, ready_q, frame_done_q;
  logic [NUM_DIGITS-1:0]         anodes_q;
  logic                          guard_end, slot_end;

  refresh_prescaler #(.REFRESH_DIV(REFRESH_DIV), .GUARD(GUARD)) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!enable),
    .run       (enable),
    .guard_end (guard_end),
    .slot_end  (slot_end)
  );

  function automatic logic [NUM_DIGITS-1:0] digit_anodes(
    input logic [width-1:0] idx, input logic [number_input_width-1:0] val, input logic blz);
    if (blz && idx != '0 && nibble_zero_above(val, idx)) return ANODES_OFF;
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

  // Scan FSM plus handshake; accept and commit are exclusive because
  // ready_q is high exactly when the pending slot is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= display_pkg::OFF;
      counter_q    <= '0;
      numero_q     <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      ready_q      <= 1'b1;
      anodes_q     <= ANODES_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (valid_in && ready_q) begin
        pend_q      <= numero_in;
        pend_full_q <= 1'b1;
        ready_q     <= 1'b0;
      end
      if (!enable) begin
        state_q   <= display_pkg::OFF;
        counter_q <= '0;
        anodes_q  <= ANODES_OFF;
        if (state_q == display_pkg::OFF && pend_full_q) begin
          numero_q    <= pend_q;
          pend_full_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      end else begin
        case (state_q)
          display_pkg::OFF: begin
            state_q  <= display_pkg::GUARD;
            anodes_q <= ANODES_OFF;
            if (pend_full_q) begin
              numero_q    <= pend_q;
              pend_full_q <= 1'b0;
              ready_q     <= 1'b1;
            end
          end
          display_pkg::GUARD: begin
            if (guard_end) begin
              state_q  <= display_pkg::ON;
              anodes_q <= digit_anodes(counter_q, numero_q, blank_lz);
            end else begin
              anodes_q <= ANODES_OFF;
            end
          end
          display_pkg::ON: begin
            if (slot_end) begin
              state_q   <= display_pkg::GUARD;
              counter_q <= counter_q + width'(1);
              anodes_q  <= ANODES_OFF;
              if (counter_q == width'(NUM_DIGITS - 1)) begin
                frame_done_q <= 1'b1;
                if (pend_full_q) begin
                  numero_q    <= pend_q;
                  pend_full_q <= 1'b0;
                  ready_q     <= 1'b1;
                end
              end
            end else begin
              anodes_q <= digit_anodes(counter_q, numero_q, blank_lz);
            end
          end
          default: begin
            state_q  <= display_pkg::OFF;
            anodes_q <= ANODES_OFF;
          end
        endcase
      end
    end
  end

  assign ready_out  = ready_q;
  assign numero     = numero_q;
  assign counter    = counter_q;
  assign anodes     = anodes_q;
  assign frame_done = frame_done_q;

endmodule
